fifo_sync_param: RTL

Parametrised single-clock synchronous FIFO that generalises the team's fixed 16x8 FIFO. Data width, depth and the almost-empty/almost-full thresholds are parameters. The block uses the full DEPTH of storage, supports a simultaneous read and write at full, and adds an occupancy count and sticky overflow/underflow error flags. It sits between a producer and a consumer in the same clock domain, with the same flag set and the same WE/RE strobe style as the existing FIFO.

---
 rtl/fifo_pkg.sv | 34 +++
 rtl/fifo_ram.sv | 33 +++
 rtl/fifo_sync_param.sv | 129 ++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the parameterised synchronous FIFO.
//   fifo_clog2      : ceiling log2, sizes the pointers and the occupancy count
//   FIFO_*_DEF      : default WIDTH / DEPTH / AE_LEVEL / AF_LEVEL
//   fifo_params_ok  : legality check on the parameter set
package fifo_pkg;

    localparam int unsigned FIFO_WIDTH_DEF    = 8;
    localparam int unsigned FIFO_DEPTH_DEF    = 16;
    localparam int unsigned FIFO_AE_LEVEL_DEF = 3;
    localparam int unsigned FIFO_AF_LEVEL_DEF = 12;

    function automatic int unsigned fifo_clog2(input int unsigned value);
        int unsigned result;
        int unsigned span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span << 1;
            result = result + 1;
        end
        return result;
    endfunction

    // DEPTH must be a power of two so the pointer low bits address the RAM
    // directly and the extra MSB acts as the wrap bit.
    function automatic bit fifo_params_ok(input int unsigned width,
                                          input int unsigned depth,
                                          input int unsigned ae_level,
                                          input int unsigned af_level);
        return (width >= 1) && (depth >= 4) && ((depth & (depth - 1)) == 0) &&
               (ae_level < depth) && (af_level > 0) && (af_level <= depth);
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// WIDTH x DEPTH dual-port storage for the FIFO.
//   clk   : write clock
//   we    : write enable, stores wdata at waddr on the rising edge
//   waddr : write address
//   wdata : write data
//   raddr : read address (asynchronous read)
//   rdata : word currently stored at raddr
// Contents are not reset; the owning FIFO only reads locations it has written.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = FIFO_WIDTH_DEF,
    parameter int unsigned DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                          clk,
    input  logic                          we,
    input  logic [fifo_clog2(DEPTH)-1:0]  waddr,
    input  logic [WIDTH-1:0]              wdata,
    input  logic [fifo_clog2(DEPTH)-1:0]  raddr,
    output logic [WIDTH-1:0]              rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_param.sv
// Parameterised single-clock FIFO with occupancy count and sticky error flags.
//   CLK, RESET : clock, synchronous active-high reset
//   DIN, WE    : write data and write strobe
//   RE         : read strobe
//   DOUT       : registered read data, holds when no read is accepted
//   EF / PEF   : empty / almost-empty (COUNT <= AE_LEVEL)
//   FF / PFF   : full / almost-full (COUNT >= AF_LEVEL)
//   COUNT      : occupancy 0..DEPTH
//   OVF / UDF  : sticky overflow / underflow, cleared only by RESET
// All outputs are decodes of registers; no combinational path from inputs.
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH    = FIFO_WIDTH_DEF,
    parameter int unsigned DEPTH    = FIFO_DEPTH_DEF,
    parameter int unsigned AE_LEVEL = FIFO_AE_LEVEL_DEF,
    parameter int unsigned AF_LEVEL = FIFO_AF_LEVEL_DEF
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic [WIDTH-1:0]            DIN,
    input  logic                        WE,
    input  logic                        RE,
    output logic [WIDTH-1:0]            DOUT,
    output logic                        EF,
    output logic                        PEF,
    output logic                        FF,
    output logic                        PFF,
    output logic [fifo_clog2(DEPTH):0]  COUNT,
    output logic                        OVF,
    output logic                        UDF
);

    localparam int unsigned AW = fifo_clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    generate
        if (!fifo_params_ok(WIDTH, DEPTH, AE_LEVEL, AF_LEVEL)) begin : g_param_check
            $error("fifo_sync_param: illegal WIDTH/DEPTH/AE_LEVEL/AF_LEVEL combination");
        end
    endgenerate

    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [PW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;

    logic             ef, ff;
    logic             rd_acc, wr_acc;
    logic [WIDTH-1:0] ram_rdata;

    assign ef  = (count_q == '0);
    assign ff  = (count_q == PW'(DEPTH));
    assign EF  = ef;
    assign FF  = ff;
    assign PEF = (count_q <= PW'(AE_LEVEL));
    assign PFF = (count_q >= PW'(AF_LEVEL));

    assign COUNT = count_q;
    assign DOUT  = dout_q;
    assign OVF   = ovf_q;
    assign UDF   = udf_q;

    // A write at full is only accepted when a read frees the slot in the
    // same cycle; at empty the read is rejected, so the write stands alone.
    assign rd_acc = RE & ~ef;
    assign wr_acc = WE & (~ff | rd_acc);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        dout_d  = dout_q;
        ovf_d   = ovf_q | (WE & ff & ~RE);
        udf_d   = udf_q | (RE & ef);

        if (wr_acc) begin
            wptr_d = wptr_q + PW'(1);
        end
        if (rd_acc) begin
            rptr_d = rptr_q + PW'(1);
            dout_d = ram_rdata;
        end

        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + PW'(1);
            2'b01:   count_d = count_q - PW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            dout_q  <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            dout_q  <= dout_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Only the low pointer bits address storage; the wrap bits are kept so
    // the pointers read naturally (modulo 2*DEPTH) when debugging.
    logic unused_wrap_bits;
    assign unused_wrap_bits = wptr_q[AW] ^ rptr_q[AW];

    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (CLK),
        .we    (wr_acc & ~RESET),
        .waddr (wptr_q[AW-1:0]),
        .wdata (DIN),
        .raddr (rptr_q[AW-1:0]),
        .rdata (ram_rdata)
    );

endmodule
